// File: rtl/hdmi_island_scheduler_pkg.sv
// Shared types and lengths for HDMI data-island scheduling.
package hdmi_island_pkg;

   typedef enum logic [1:0] {
      CTRL        = 2'd0,
      DI_PREAMBLE = 2'd1,
      DI_GUARD    = 2'd2,
      DI_DATA     = 2'd3
   } hdmi_period_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_GUARD_L,
      S_DATA,
      S_GUARD_T,
      S_DONE
   } island_state_t;

   localparam int DI_PREAMBLE_LEN = 8;
   localparam int DI_GUARD_LEN    = 2;
   localparam int DI_PACKET_LEN   = 32;

endpackage

// File: rtl/hdmi_island_scheduler_if.sv
// Pixel-timing inputs, packet request/grant and per-pixel period outputs of the island scheduler.
interface hdmi_island_if #(parameter int NUM_SOURCES = 4);
   import hdmi_island_pkg::*;

   logic                   blank;
   logic [11:0]            blank_remaining;
   logic [NUM_SOURCES-1:0] pkt_req;
   hdmi_period_t           period;
   logic [NUM_SOURCES-1:0] pkt_grant;
   logic                   pkt_start;
   logic [4:0]             pkt_bit;
   logic                   island_busy;
   logic                   island_abort;

   modport master (
      input  blank, blank_remaining, pkt_req,
      output period, pkt_grant, pkt_start, pkt_bit, island_busy, island_abort
   );

   modport slave (
      output blank, blank_remaining, pkt_req,
      input  period, pkt_grant, pkt_start, pkt_bit, island_busy, island_abort
   );

endinterface

// File: rtl/hdmi_island_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from the pointer, which
// moves past the grantee only when advance coincides with a real grant.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic               clk_pixel,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_next;
   logic [PTR_W-1:0] idx;
   logic             found;

   always_comb begin
      grant    = '0;
      ptr_next = ptr;
      idx      = '0;
      found    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            ptr_next   = PTR_W'((int'(ptr) + i + 1) % NUM_REQ);
         end
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (!reset_n)
         ptr <= '0;
      else if (advance && found)
         ptr <= ptr_next;
   end

endmodule

// File: rtl/hdmi_island_scheduler.sv
// Per-pixel data-island scheduler: places preamble/guard/packet periods inside blanking
// and round-robins packet slots among the packet sources.
//
//  state     | meaning
//  S_IDLE    | control period, waiting for lead-in, room and a request
//  S_PRE     | 8 island preamble pixels
//  S_GUARD_L | 2 leading guard pixels; last one arbitrates packet 0
//  S_DATA    | 32 pixels per packet; bit 31 decides next packet or trailer
//  S_GUARD_T | 2 trailing guard pixels
//  S_DONE    | island finished, wait for blank to fall
module hdmi_island_scheduler
   import hdmi_island_pkg::*;
#(
   parameter int NUM_SOURCES = 4,
   parameter int MAX_PACKETS = 18,
   parameter int CTRL_LEAD   = 12,
   parameter int TAIL_MARGIN = 22
) (
   input  logic          clk_pixel,
   input  logic          reset_n,
   hdmi_island_if.master bus
);

   localparam logic [11:0] LEAD       = 12'(CTRL_LEAD);
   localparam logic [11:0] START_MIN  = 12'(DI_PREAMBLE_LEN + DI_GUARD_LEN + DI_PACKET_LEN
                                            + DI_GUARD_LEN + TAIL_MARGIN);
   localparam logic [11:0] CONT_MIN   = 12'(DI_PACKET_LEN + DI_GUARD_LEN + TAIL_MARGIN);
   localparam logic [3:0]  PRE_LAST   = 4'(DI_PREAMBLE_LEN);
   localparam logic [3:0]  GUARD_LAST = 4'(DI_GUARD_LEN);
   localparam logic [4:0]  PKT_MAX    = 5'(MAX_PACKETS);
   localparam logic [4:0]  BIT_LAST   = 5'(DI_PACKET_LEN - 1);

   island_state_t          state;
   logic [11:0]            blank_cnt;
   logic [3:0]             px_cnt;
   logic [4:0]             pkt_cnt;
   hdmi_period_t           period_r;
   logic [NUM_SOURCES-1:0] grant_r;
   logic                   start_r;
   logic [4:0]             bit_r;
   logic                   busy_r;
   logic                   abort_r;
   logic [NUM_SOURCES-1:0] arb_grant;
   logic                   arb_advance;
   logic                   cont_ok;
   logic                   start_ok;

   assign start_ok = bus.blank && (blank_cnt >= LEAD) && (|bus.pkt_req)
                     && (bus.blank_remaining >= START_MIN);
   assign cont_ok  = (|bus.pkt_req) && (pkt_cnt < PKT_MAX) && (bus.blank_remaining > CONT_MIN);

   // An abort (blank low) must never consume a grant.
   assign arb_advance = reset_n && bus.blank &&
                        (((state == S_GUARD_L) && (px_cnt == GUARD_LAST)) ||
                         ((state == S_DATA) && (bit_r == BIT_LAST) && cont_ok));

   rr_arbiter #(.NUM_REQ(NUM_SOURCES)) u_arb (
      .clk_pixel (clk_pixel),
      .reset_n   (reset_n),
      .req       (bus.pkt_req),
      .advance   (arb_advance),
      .grant     (arb_grant)
   );

   always_ff @(posedge clk_pixel) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         blank_cnt <= '0;
         px_cnt    <= '0;
         pkt_cnt   <= '0;
         period_r  <= CTRL;
         grant_r   <= '0;
         start_r   <= 1'b0;
         bit_r     <= '0;
         busy_r    <= 1'b0;
         abort_r   <= 1'b0;
      end else begin
         start_r <= 1'b0;
         abort_r <= 1'b0;
         if (!bus.blank)
            blank_cnt <= '0;
         else if (blank_cnt != '1)
            blank_cnt <= blank_cnt + 12'd1;

         if (!bus.blank && (state != S_IDLE) && (state != S_DONE)) begin
            state    <= S_IDLE;
            period_r <= CTRL;
            grant_r  <= '0;
            bit_r    <= '0;
            busy_r   <= 1'b0;
            abort_r  <= busy_r;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start_ok) begin
                     state    <= S_PRE;
                     period_r <= DI_PREAMBLE;
                     px_cnt   <= 4'd1;
                     busy_r   <= 1'b1;
                  end
               end
               S_PRE: begin
                  if (px_cnt == PRE_LAST) begin
                     state    <= S_GUARD_L;
                     period_r <= DI_GUARD;
                     px_cnt   <= 4'd1;
                  end else begin
                     px_cnt <= px_cnt + 4'd1;
                  end
               end
               S_GUARD_L: begin
                  if (px_cnt == GUARD_LAST) begin
                     state    <= S_DATA;
                     period_r <= DI_DATA;
                     grant_r  <= arb_grant;
                     start_r  <= 1'b1;
                     bit_r    <= '0;
                     pkt_cnt  <= 5'd1;
                  end else begin
                     px_cnt <= px_cnt + 4'd1;
                  end
               end
               S_DATA: begin
                  if (bit_r != BIT_LAST) begin
                     bit_r <= bit_r + 5'd1;
                  end else if (cont_ok) begin
                     grant_r <= arb_grant;
                     start_r <= 1'b1;
                     bit_r   <= '0;
                     if (pkt_cnt != PKT_MAX)
                        pkt_cnt <= pkt_cnt + 5'd1;
                  end else begin
                     state    <= S_GUARD_T;
                     period_r <= DI_GUARD;
                     grant_r  <= '0;
                     bit_r    <= '0;
                     px_cnt   <= 4'd1;
                  end
               end
               S_GUARD_T: begin
                  if (px_cnt == GUARD_LAST) begin
                     state    <= S_DONE;
                     period_r <= CTRL;
                     busy_r   <= 1'b0;
                  end else begin
                     px_cnt <= px_cnt + 4'd1;
                  end
               end
               S_DONE: begin
                  if (!bus.blank)
                     state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.period       = period_r;
   assign bus.pkt_grant    = grant_r;
   assign bus.pkt_start    = start_r;
   assign bus.pkt_bit      = bit_r;
   assign bus.island_busy  = busy_r;
   assign bus.island_abort = abort_r;

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Directed bench for hdmi_island_scheduler: one blanking line per scenario, outputs logged per pixel.
module tb_hdmi_island_scheduler;
   import hdmi_island_pkg::*;

   logic clk_pixel = 1'b0;
   logic reset_n   = 1'b0;
   always #5 clk_pixel = ~clk_pixel;

   hdmi_island_if #(.NUM_SOURCES(4)) bus();

   hdmi_island_scheduler #(
      .NUM_SOURCES (4),
      .MAX_PACKETS (18),
      .CTRL_LEAD   (12),
      .TAIL_MARGIN (22)
   ) dut (
      .clk_pixel (clk_pixel),
      .reset_n   (reset_n),
      .bus       (bus.master)
   );

   int vectors     = 0;
   int miscompares = 0;

   localparam int LOG_N = 1100;
   logic [1:0] lp    [LOG_N];
   logic [3:0] lg    [LOG_N];
   logic       ls    [LOG_N];
   logic [4:0] lb    [LOG_N];
   logic       lbusy [LOG_N];
   logic       lab   [LOG_N];
   int         n_log;

   // Expected period for an island whose first preamble pixel is s and which carries npk packets.
   function automatic logic [1:0] exp_period(input int i, input int s, input int npk);
      if (i < s)                  return 2'd0;
      if (i < s + 8)              return 2'd1;
      if (i < s + 10)             return 2'd2;
      if (i < s + 10 + 32 * npk)  return 2'd3;
      if (i < s + 12 + 32 * npk)  return 2'd2;
      return 2'd0;
   endfunction

   task automatic pixel(input logic b, input logic [11:0] rem, input logic rn);
      bus.blank           = b;
      bus.blank_remaining = rem;
      reset_n             = rn;
      @(posedge clk_pixel);
      #1;
   endtask

   // One blanking line of blen pixels (remaining = blen - i), then 4 active pixels.
   // cut_at >= 0 ends blanking early there: blank falls, or reset_n pulses when cut_reset.
   task automatic run_line(input int blen, input logic [3:0] req0, input logic [3:0] drop_mask,
                           input int cut_at, input bit cut_reset, input int drop_at);
      int         line_end;
      logic [3:0] req;
      line_end = (cut_at >= 0) ? cut_at : blen;
      req      = req0;
      n_log    = line_end + 4;
      for (int i = 0; i < n_log; i++) begin
         if (i == drop_at) req = '0;
         bus.pkt_req = req;
         if (i < line_end)                      pixel(1'b1, 12'(blen - i), 1'b1);
         else if (cut_reset && i == line_end)   pixel(1'b1, 12'(blen - i), 1'b0);
         else                                   pixel(1'b0, 12'd0, 1'b1);
         lp[i]    = bus.period;
         lg[i]    = bus.pkt_grant;
         ls[i]    = bus.pkt_start;
         lb[i]    = bus.pkt_bit;
         lbusy[i] = bus.island_busy;
         lab[i]   = bus.island_abort;
         if (bus.pkt_start && ((bus.pkt_grant & drop_mask) != 4'd0))
            req = req & ~bus.pkt_grant;
      end
      reset_n     = 1'b1;
      bus.pkt_req = '0;
   endtask

   task automatic test_reset();
      bus.pkt_req = '0;
      repeat (3) pixel(1'b0, 12'd0, 1'b0);
      vectors++;
      if (bus.period !== 2'd0 || bus.pkt_grant !== 4'd0 || bus.pkt_start !== 1'b0 ||
          bus.pkt_bit !== 5'd0 || bus.island_busy !== 1'b0 || bus.island_abort !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs got per=%0d grant=%b start=%0b bit=%0d busy=%0b abort=%0b want all 0",
                  bus.period, bus.pkt_grant, bus.pkt_start, bus.pkt_bit, bus.island_busy, bus.island_abort);
      end
      repeat (2) pixel(1'b0, 12'd0, 1'b1);
   endtask

   // Fresh pointer after reset: grants rotate 0,1,2,3,0,...; 11 packets fit in 400 pixels.
   task automatic test_back_to_back();
      logic [1:0] ep; logic [4:0] eb; logic es; logic [3:0] eg;
      run_line(400, 4'b1111, 4'b0000, -1, 1'b0, -1);
      for (int i = 0; i < n_log; i++) begin
         ep = exp_period(i, 12, 11);
         eb = (ep == 2'd3) ? 5'((i - 22) % 32) : 5'd0;
         es = (ep == 2'd3) && ((i - 22) % 32 == 0);
         eg = (ep == 2'd3) ? 4'(1 << (((i - 22) / 32) % 4)) : 4'd0;
         vectors++;
         if (lp[i] !== ep || lb[i] !== eb || ls[i] !== es || lg[i] !== eg) begin
            miscompares++;
            $display("FAIL b2b px%0d got per=%0d bit=%0d start=%0b grant=%b want per=%0d bit=%0d start=%0b grant=%b",
                     i, lp[i], lb[i], ls[i], lg[i], ep, eb, es, eg);
         end
      end
   endtask

   task automatic test_basic();
      logic [1:0] ep; logic [4:0] eb; logic es; logic [3:0] eg; logic ebz;
      int busy_n;
      busy_n = 0;
      run_line(160, 4'b0001, 4'b0001, -1, 1'b0, -1);
      for (int i = 0; i < n_log; i++) begin
         ep  = exp_period(i, 12, 1);
         eb  = (ep == 2'd3) ? 5'(i - 22) : 5'd0;
         es  = (i == 22);
         eg  = (ep == 2'd3) ? 4'b0001 : 4'd0;
         ebz = (i >= 12) && (i < 56);
         if (lbusy[i]) busy_n++;
         vectors++;
         if (lp[i] !== ep || lb[i] !== eb || ls[i] !== es || lg[i] !== eg ||
             lbusy[i] !== ebz || lab[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL basic px%0d got per=%0d bit=%0d start=%0b grant=%b busy=%0b abort=%0b want per=%0d bit=%0d start=%0b grant=%b busy=%0b abort=0",
                     i, lp[i], lb[i], ls[i], lg[i], lbusy[i], lab[i], ep, eb, es, eg, ebz);
         end
      end
      vectors++;
      if (busy_n !== 44) begin
         miscompares++;
         $display("FAIL basic_busy_len got %0d want 44", busy_n);
      end
   endtask

   // 66 remaining at the lead-in pixel is exactly enough room.
   task automatic test_min_remaining();
      run_line(78, 4'b0001, 4'b0001, -1, 1'b0, -1);
      vectors++;
      if (lp[11] !== 2'd0 || lp[12] !== 2'd1 || lp[55] !== 2'd2 || lp[56] !== 2'd0 || lg[22] !== 4'b0001) begin
         miscompares++;
         $display("FAIL min_room got per11=%0d per12=%0d per55=%0d per56=%0d grant22=%b want 0 1 2 0 0001",
                  lp[11], lp[12], lp[55], lp[56], lg[22]);
      end
   endtask

   task automatic test_no_island();
      run_line(77, 4'b0001, 4'b0001, -1, 1'b0, -1);
      for (int i = 0; i < n_log; i++) begin
         vectors++;
         if (lp[i] !== 2'd0 || lg[i] !== 4'd0 || lbusy[i] !== 1'b0) begin
            miscompares++;
            $display("FAIL no_island px%0d got per=%0d grant=%b busy=%0b want 0 0000 0",
                     i, lp[i], lg[i], lbusy[i]);
         end
      end
   endtask

   task automatic test_null_packet();
      run_line(160, 4'b0001, 4'b0000, -1, 1'b0, 15);
      vectors++;
      if (lp[12] !== 2'd1 || lp[22] !== 2'd3 || ls[22] !== 1'b1 || lg[22] !== 4'd0 ||
          lp[54] !== 2'd2 || lp[56] !== 2'd0) begin
         miscompares++;
         $display("FAIL null_pkt got per12=%0d per22=%0d start22=%0b grant22=%b per54=%0d per56=%0d want 1 3 1 0000 2 0",
                  lp[12], lp[22], ls[22], lg[22], lp[54], lp[56]);
      end
   endtask

   task automatic test_max_packets();
      logic [1:0] ep; logic [3:0] eg; logic es;
      int starts;
      starts = 0;
      run_line(1000, 4'b0001, 4'b0000, -1, 1'b0, -1);
      for (int i = 0; i < n_log; i++) begin
         ep = exp_period(i, 12, 18);
         eg = (ep == 2'd3) ? 4'b0001 : 4'd0;
         es = (ep == 2'd3) && ((i - 22) % 32 == 0);
         if (ls[i]) starts++;
         vectors++;
         if (lp[i] !== ep || lg[i] !== eg || ls[i] !== es) begin
            miscompares++;
            $display("FAIL max_pkts px%0d got per=%0d grant=%b start=%0b want per=%0d grant=%b start=%0b",
                     i, lp[i], lg[i], ls[i], ep, eg, es);
         end
      end
      vectors++;
      if (starts !== 18) begin
         miscompares++;
         $display("FAIL max_pkts_count got %0d want 18", starts);
      end
   endtask

   // DATA bit 10 would be pixel 32; blank falls there instead.
   task automatic test_abort();
      run_line(160, 4'b0001, 4'b0000, 32, 1'b0, -1);
      vectors++;
      if (lp[31] !== 2'd3 || lb[31] !== 5'd9 || lab[31] !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_pre got per=%0d bit=%0d abort=%0b want 3 9 0", lp[31], lb[31], lab[31]);
      end
      vectors++;
      if (lp[32] !== 2'd0 || lg[32] !== 4'd0 || lab[32] !== 1'b1 || lbusy[32] !== 1'b0 || lb[32] !== 5'd0) begin
         miscompares++;
         $display("FAIL abort_cut got per=%0d grant=%b abort=%0b busy=%0b bit=%0d want 0 0000 1 0 0",
                  lp[32], lg[32], lab[32], lbusy[32], lb[32]);
      end
      vectors++;
      if (lab[33] !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_pulse_len got abort=%0b want 0", lab[33]);
      end
      run_line(160, 4'b0001, 4'b0001, -1, 1'b0, -1);
      vectors++;
      if (lp[12] !== 2'd1 || lg[22] !== 4'b0001 || lp[56] !== 2'd0) begin
         miscompares++;
         $display("FAIL abort_next_line got per12=%0d grant22=%b per56=%0d want 1 0001 0",
                  lp[12], lg[22], lp[56]);
      end
   endtask

   // Pointer sits at source 1 here; a reset must bring it back to source 0.
   task automatic test_reset_mid();
      run_line(160, 4'b1111, 4'b1111, 27, 1'b1, -1);
      vectors++;
      if (lg[22] !== 4'b0010 || lp[26] !== 2'd3 || lb[26] !== 5'd4) begin
         miscompares++;
         $display("FAIL rst_mid_pre got grant22=%b per26=%0d bit26=%0d want 0010 3 4", lg[22], lp[26], lb[26]);
      end
      vectors++;
      if (lp[27] !== 2'd0 || lg[27] !== 4'd0 || ls[27] !== 1'b0 || lb[27] !== 5'd0 ||
          lbusy[27] !== 1'b0 || lab[27] !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_mid_out got per=%0d grant=%b start=%0b bit=%0d busy=%0b abort=%0b want all 0",
                  lp[27], lg[27], ls[27], lb[27], lbusy[27], lab[27]);
      end
      run_line(160, 4'b1111, 4'b1111, -1, 1'b0, -1);
      vectors++;
      if (lp[12] !== 2'd1 || lg[22] !== 4'b0001) begin
         miscompares++;
         $display("FAIL rst_mid_ptr got per12=%0d grant22=%b want 1 0001", lp[12], lg[22]);
      end
   endtask

   initial begin
      bus.blank           = 1'b0;
      bus.blank_remaining = 12'd0;
      bus.pkt_req         = '0;
      test_reset();
      test_back_to_back();
      test_basic();
      test_min_remaining();
      test_no_island();
      test_null_packet();
      test_max_packets();
      test_abort();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
